// File: rtl/vcnt_sched_pkg.sv
// rtl/vcnt_sched_pkg.sv - shared constants and types for the vertical-count compare scheduler
// Contents: CNT_W (comparator width), NUM_SLOTS, SLOT_W, slot_idx_t, sched_state_t.
package vcnt_sched_pkg;

   // Width is pinned by the shared m_EQU9 comparator; do not change.
   localparam int CNT_W     = 9;
   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = $clog2(NUM_SLOTS);

   typedef logic [SLOT_W-1:0] slot_idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } sched_state_t;

endpackage

// File: rtl/m_EQU9.sv
// rtl/m_EQU9.sv - 9-bit gated equality comparator
// Ports:
//   A, B  in  9 : operands
//   EN    in  1 : compare enable; EQ is forced low when EN is low
//   EQ    out 1 : A == B qualified by EN
module m_EQU9 (
   input  logic [8:0] A,
   input  logic [8:0] B,
   input  logic       EN,
   output logic       EQ
);

   assign EQ = EN & (A == B);

endmodule

// File: rtl/vcnt_cmp_sched.sv
// rtl/vcnt_cmp_sched.sv - four-slot vertical-line compare scheduler sharing one m_EQU9
// Optional feature macro: VCNT_CMP_SCHED_IRQ_EN (adds irq / irq_ack, last slot is the interrupt line).
// Ports:
//   MasterClock in  1         : clock, rising edge
//   nReset      in  1         : asynchronous active-low reset
//   vcnt        in  CNT_W     : vertical line count, sampled on line_start
//   line_start  in  1         : new-line strobe, starts a scan when idle
//   wr_en       in  1         : target write strobe
//   wr_slot     in  SLOT_W    : target index
//   wr_data     in  CNT_W     : target value
//   slot_en     in  NUM_SLOTS : per-slot compare enable, sampled live during that slot's scan cycle
//   busy        out 1         : scan in progress (SCAN or DONE)
//   hit         out NUM_SLOTS : match vector of the last completed scan
//   hit_valid   out 1         : one-cycle pulse when hit updates
//   overrun     out 1         : sticky, line_start seen while busy
//   ovr_clr     in  1         : clears overrun (a new overrun wins)
//   irq         out 1         : line interrupt (macro only)
//   irq_ack     in  1         : clears irq, a new set wins (macro only)
module vcnt_cmp_sched
   import vcnt_sched_pkg::*;
(
   input  logic                 MasterClock,
   input  logic                 nReset,
   input  logic [CNT_W-1:0]     vcnt,
   input  logic                 line_start,
   input  logic                 wr_en,
   input  logic [SLOT_W-1:0]    wr_slot,
   input  logic [CNT_W-1:0]     wr_data,
   input  logic [NUM_SLOTS-1:0] slot_en,
   output logic                 busy,
   output logic [NUM_SLOTS-1:0] hit,
   output logic                 hit_valid,
   output logic                 overrun,
   input  logic                 ovr_clr
`ifdef VCNT_CMP_SCHED_IRQ_EN
   ,
   output logic                 irq,
   input  logic                 irq_ack
`endif
);

   localparam slot_idx_t LAST_IDX = slot_idx_t'(NUM_SLOTS - 1);

   sched_state_t         state;
   sched_state_t         state_next;
   slot_idx_t            idx;
   logic [CNT_W-1:0]     vcnt_q;
   logic [NUM_SLOTS-1:0] hit_acc;
   logic [CNT_W-1:0]     target [NUM_SLOTS];
   logic                 eq;

   // Single shared comparator: one slot per cycle, selected by idx.
   m_EQU9 u_equ (
      .A  (vcnt_q[8:0]),
      .B  (target[idx][8:0]),
      .EN (slot_en[idx]),
      .EQ (eq)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge MasterClock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (line_start) state_next = SCAN;
         SCAN:    if (idx == LAST_IDX) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge MasterClock or negedge nReset) begin
      if (!nReset) begin
         idx       <= '0;
         vcnt_q    <= '0;
         hit_acc   <= '0;
         hit       <= '0;
         hit_valid <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            target[i] <= '0;
         end
      end else begin
         // Writes land at the edge, so a compare in the same cycle sees the old value.
         if (wr_en) begin
            target[wr_slot] <= wr_data;
         end

         hit_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (line_start) begin
                  vcnt_q  <= vcnt;
                  idx     <= '0;
                  hit_acc <= '0;
               end
            end
            SCAN: begin
               hit_acc[idx] <= eq;
               idx          <= idx + slot_idx_t'(1);
            end
            DONE: begin
               hit       <= hit_acc;
               hit_valid <= 1'b1;
            end
            default: ;
         endcase

         // A strobe during SCAN or DONE is dropped; flag it, set beats clear.
         if (line_start && busy) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

`ifdef VCNT_CMP_SCHED_IRQ_EN
   always_ff @(posedge MasterClock or negedge nReset) begin
      if (!nReset) begin
         irq <= 1'b0;
      end else if (state == DONE && hit_acc[LAST_IDX]) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_vcnt_cmp_sched.sv
// tb/tb_vcnt_cmp_sched.sv - scoreboard testbench for vcnt_cmp_sched
module tb_vcnt_cmp_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] vcnt;
   logic       line_start;
   logic       wr_en;
   logic [1:0] wr_slot;
   logic [8:0] wr_data;
   logic [3:0] slot_en;
   logic       busy;
   logic [3:0] hit;
   logic       hit_valid;
   logic       overrun;
   logic       ovr_clr;
`ifdef VCNT_CMP_SCHED_IRQ_EN
   logic       irq;
   logic       irq_ack;
`endif

   typedef struct {
      logic [3:0] hit;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   vcnt_cmp_sched dut (
      .MasterClock (clk),
      .nReset      (rst_n),
      .vcnt        (vcnt),
      .line_start  (line_start),
      .wr_en       (wr_en),
      .wr_slot     (wr_slot),
      .wr_data     (wr_data),
      .slot_en     (slot_en),
      .busy        (busy),
      .hit         (hit),
      .hit_valid   (hit_valid),
      .overrun     (overrun),
      .ovr_clr     (ovr_clr)
`ifdef VCNT_CMP_SCHED_IRQ_EN
      ,
      .irq         (irq),
      .irq_ack     (irq_ack)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every hit_valid pulse must match the oldest pending expectation,
   // both in value and in the cycle it appears.
   always @(negedge clk) begin
      if (rst_n && hit_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_hit_valid: got hit %b expected no pulse (cycle %0d)", hit, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (hit !== e.hit || cyc != e.due) begin
               errors++;
               $display("FAIL scoreboard_hit: got %b at cycle %0d expected %b at cycle %0d",
                        hit, cyc, e.hit, e.due);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_target(input logic [1:0] s, input logic [8:0] d);
      wr_en   = 1'b1;
      wr_slot = s;
      wr_data = d;
      step(1);
      wr_en   = 1'b0;
   endtask

   task automatic strobe_raw(input logic [8:0] v);
      line_start = 1'b1;
      vcnt       = v;
      step(1);
      line_start = 1'b0;
   endtask

   // Accepted strobe: the result shows up on the negedge after edge 5 (cyc+6).
   task automatic strobe(input logic [8:0] v, input logic [3:0] exp_hit);
      exp_t e;
      e.hit = exp_hit;
      e.due = cyc + 6;
      exp_q.push_back(e);
      strobe_raw(v);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy || exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy %0b pending %0d expected idle with 0 pending", name, busy, exp_q.size());
      end
      step(1);
   endtask

   task automatic set_targets(input logic [8:0] t0, input logic [8:0] t1,
                              input logic [8:0] t2, input logic [8:0] t3);
      write_target(2'd0, t0);
      write_target(2'd1, t1);
      write_target(2'd2, t2);
      write_target(2'd3, t3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      vcnt       = '0;
      line_start = 1'b0;
      wr_en      = 1'b0;
      wr_slot    = '0;
      wr_data    = '0;
      slot_en    = 4'b1111;
      ovr_clr    = 1'b0;
`ifdef VCNT_CMP_SCHED_IRQ_EN
      irq_ack    = 1'b0;
`endif
      step(2);
      chk("reset_hit", hit, 4'b0000);
      chk("reset_hit_valid", hit_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
`ifdef VCNT_CMP_SCHED_IRQ_EN
      chk("reset_irq", irq, 1'b0);
`endif
      rst_n = 1'b1;
      step(1);

      // Basic match on slot 2.
      set_targets(9'd10, 9'd20, 9'd30, 9'd40);
      strobe(9'd30, 4'b0100);
      chk("busy_in_scan", busy, 1'b1);
      wait_drain("basic");
      chk("hit_holds", hit, 4'b0100);

      // Disabled slots never hit.
      set_targets(9'd7, 9'd7, 9'd7, 9'd7);
      slot_en = 4'b1010;
      strobe(9'd7, 4'b1010);
      wait_drain("slot_en");

      // Overrun: second strobe 3 cycles in is ignored.
      slot_en = 4'b1111;
      set_targets(9'd10, 9'd20, 9'd30, 9'd40);
      strobe(9'd10, 4'b0001);
      step(2);
      strobe_raw(9'd40);
      chk("overrun_set", overrun, 1'b1);
      wait_drain("overrun");
      chk("overrun_sticky", overrun, 1'b1);
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;
      chk("overrun_clr", overrun, 1'b0);

      // Strobe during DONE counts as overrun.
      strobe(9'd20, 4'b0010);
      step(4);
      strobe_raw(9'd30);
      chk("overrun_done_cycle", overrun, 1'b1);
      wait_drain("done_ovr");
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;

      // Minimum spacing of 6 cycles is accepted.
      strobe(9'd40, 4'b1000);
      step(5);
      strobe(9'd20, 4'b0010);
      chk("no_overrun_spacing6", overrun, 1'b0);
      wait_drain("spacing");

      // Overrun set beats ovr_clr in the same cycle.
      strobe(9'd10, 4'b0001);
      step(1);
      line_start = 1'b1;
      ovr_clr    = 1'b1;
      step(1);
      line_start = 1'b0;
      ovr_clr    = 1'b0;
      chk("overrun_set_wins", overrun, 1'b1);
      wait_drain("set_wins");
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;

      // Write to slot 2 during its compare cycle: old value is compared.
      set_targets(9'd10, 9'd20, 9'd50, 9'd40);
      strobe(9'd50, 4'b0100);
      step(2);
      write_target(2'd2, 9'd60);
      wait_drain("wr_during_cmp");
      strobe(9'd60, 4'b0100);
      wait_drain("wr_new_value");

      // All-ones and all-zeros targets.
      set_targets(9'd0, 9'd0, 9'd0, 9'h1FF);
      strobe(9'h1FF, 4'b1000);
      wait_drain("all_ones");
      strobe(9'd0, 4'b0111);
      wait_drain("all_zeros");

`ifdef VCNT_CMP_SCHED_IRQ_EN
      chk("irq_set", irq, 1'b1);
      step(3);
      chk("irq_hold", irq, 1'b1);
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      chk("irq_ack_clr", irq, 1'b0);
      // Re-set lands on the same edge as an ack: irq stays set.
      strobe(9'h1FF, 4'b1000);
      step(4);
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      chk("irq_set_wins", irq, 1'b1);
      wait_drain("irq_rearm");
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
`endif

      // slot_en sampled live: disabled after slot 0's compare cycle.
      set_targets(9'd7, 9'd7, 9'd7, 9'd7);
      slot_en = 4'b1111;
      strobe(9'd7, 4'b0001);
      step(1);
      slot_en = 4'b0000;
      wait_drain("slot_en_live");
      slot_en = 4'b1111;
      chk("hit_before_reset", hit, 4'b0001);

      // Reset mid-scan aborts without a result.
      strobe_raw(9'd7);
      step(2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_hit", hit, 4'b0000);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_hit_valid", hit_valid, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(10);
      chk("no_hit_valid_after_rst", hit, 4'b0000);

      // Targets back to zero after reset.
      strobe(9'd0, 4'b1111);
      wait_drain("targets_zero");

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
